// File: rtl/apb_mem_arbiter_pkg.sv
// Shared types for the two-port APB memory arbiter.
package apb_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/apb_mem_arbiter_if.sv
// APB slave-side signal bundle for one arbiter port.
interface apb_mem_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12
) ();
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [NUM_BYTES-1:0]  pstrb;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_mem_arbiter_rr_arb2.sv
// Two-request arbiter. Round-robin by default; define APB_MEM_ARB_FIXED_PRIO_EN
// for fixed priority (port 0 always wins, no pointer register).
module rr_arb2
   import apb_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   input  port_id_t   served_i,
   output port_id_t   grant_o
);

`ifdef APB_MEM_ARB_FIXED_PRIO_EN
   logic unused_ok;
   assign unused_ok = ^{clk, rst, advance_i, served_i};

   // Port 1 wins only when port 0 is not requesting.
   always_comb begin
      grant_o = (req_i[1] && !req_i[0]) ? PORT1 : PORT0;
   end
`else
   port_id_t ptr_q;

   // Pointer hands priority to the port that was not just served.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= PORT0;
      end else if (advance_i) begin
         ptr_q <= ~served_i;
      end
   end

   // Single requester wins outright; contention resolved by the pointer.
   always_comb begin
      if (req_i[0] && req_i[1]) begin
         grant_o = ptr_q;
      end else begin
         grant_o = req_i[1] ? PORT1 : PORT0;
      end
   end
`endif

endmodule

// File: rtl/apb_mem_arbiter.sv
// Two-port APB front end sharing one single-port byte-enabled memory.
// Optional build macro: APB_MEM_ARB_FIXED_PRIO_EN (fixed priority, port 0 wins).
module apb_mem_arbiter
   import apb_mem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned MEM_SIZE   = 256,
   parameter int unsigned MEM_AW     = $clog2(MEM_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   apb_mem_arbiter_if.slave      s0,
   apb_mem_arbiter_if.slave      s1,
   output logic                  mem_wr,
   output logic                  mem_rd,
   output logic [NUM_BYTES-1:0]  mem_be,
   output logic [MEM_AW-1:0]     mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   arb_state_t state_q, state_d;
   port_id_t   grant_q, grant_d, arb_grant;
   logic       err_q, err_d;
   logic       rd_ok_q, rd_ok_d;

   logic                  sel_penable;
   logic                  sel_pwrite;
   logic [ADDR_WIDTH-1:0] sel_paddr;
   logic [DATA_WIDTH-1:0] sel_pwdata;
   logic [NUM_BYTES-1:0]  sel_pstrb;
   logic                  addr_err;
   logic                  access_fire;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     ({s1.psel, s0.psel}),
      .advance_i (state_q == RESP),
      .served_i  (grant_q),
      .grant_o   (arb_grant)
   );

   // Route the granted port's request signals to the shared datapath.
   always_comb begin
      if (grant_q == PORT1) begin
         sel_penable = s1.penable;
         sel_pwrite  = s1.pwrite;
         sel_paddr   = s1.paddr;
         sel_pwdata  = s1.pwdata;
         sel_pstrb   = s1.pstrb;
      end else begin
         sel_penable = s0.penable;
         sel_pwrite  = s0.pwrite;
         sel_paddr   = s0.paddr;
         sel_pwdata  = s0.pwdata;
         sel_pstrb   = s0.pstrb;
      end
      addr_err = (sel_paddr[1:0] != 2'b00) ||
                 (32'(sel_paddr[ADDR_WIDTH-1:2]) >= 32'(MEM_SIZE));
      // rst kills a strobe in the same cycle so an in-flight access is aborted.
      access_fire = (state_q == ACCESS) && sel_penable && !rst;
   end

   // State, grant and response-qualifier registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= PORT0;
         err_q   <= 1'b0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         err_q   <= err_d;
         rd_ok_q <= rd_ok_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      err_d   = err_q;
      rd_ok_d = rd_ok_q;
      unique case (state_q)
         IDLE: begin
            if (s0.psel || s1.psel) begin
               grant_d = arb_grant;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (sel_penable) begin
               err_d   = addr_err;
               rd_ok_d = !addr_err && !sel_pwrite;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory strobes during ACCESS and the one-cycle APB response in RESP.
   always_comb begin
      mem_wr      = 1'b0;
      mem_rd      = 1'b0;
      mem_be      = '0;
      mem_address = '0;
      mem_data_in = '0;
      s0.pready   = 1'b0;
      s0.pslverr  = 1'b0;
      s0.prdata   = '0;
      s1.pready   = 1'b0;
      s1.pslverr  = 1'b0;
      s1.prdata   = '0;
      if (access_fire) begin
         mem_address = sel_paddr[MEM_AW+1:2];
         mem_data_in = sel_pwdata;
         if (!addr_err) begin
            if (sel_pwrite) begin
               mem_wr = 1'b1;
               mem_be = sel_pstrb;
            end else begin
               mem_rd = 1'b1;
               mem_be = '1;
            end
         end
      end
      if ((state_q == RESP) && !rst) begin
         if (grant_q == PORT1) begin
            s1.pready  = 1'b1;
            s1.pslverr = err_q;
            s1.prdata  = rd_ok_q ? mem_data_out : '0;
         end else begin
            s0.pready  = 1'b1;
            s0.pslverr = err_q;
            s0.prdata  = rd_ok_q ? mem_data_out : '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Scoreboard bench for apb_mem_arbiter: directed APB transfers on both ports,
// expected memory strobes and responses queued at issue, checked by a monitor.
module tb_apb_mem_arbiter;
   import apb_mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) s0 ();
   apb_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) s1 ();

   logic        mem_wr, mem_rd;
   logic [3:0]  mem_be;
   logic [7:0]  mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out = '0;

   apb_mem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .s0           (s0.slave),
      .s1           (s1.slave),
      .mem_wr       (mem_wr),
      .mem_rd       (mem_rd),
      .mem_be       (mem_be),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // Byte-enabled single-port memory with one-cycle registered read.
   logic [31:0] mem [256] = '{default: 32'h0};
   always @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
         end
      end
      if (mem_rd) mem_data_out <= mem[mem_address];
   end

   typedef struct packed {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   typedef struct packed {
      logic        wr;
      logic [7:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
   } mop_t;

   resp_t resp_q[$];
   mop_t  mop_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void exp_resp(input logic port, input logic err, input logic [31:0] rd);
      resp_q.push_back('{port: port, err: err, rdata: rd});
   endfunction

   function automatic void exp_mop(input logic wr, input logic [7:0] a, input logic [3:0] be,
                                   input logic [31:0] d);
      mop_q.push_back('{wr: wr, addr: a, be: be, data: d});
   endfunction

   // Monitor: every strobe and every pready is matched against the queues.
   always @(negedge clk) begin
      mop_t  m;
      resp_t r;
      if (mem_wr && mem_rd) check("strobes_exclusive", 32'(mem_wr & mem_rd), 32'd0);
      if (mem_wr || mem_rd) begin
         if (mop_q.size() == 0) begin
            check("unexpected_strobe", {mem_wr, mem_rd, 22'd0, mem_address}, 32'd0);
         end else begin
            m = mop_q.pop_front();
            check("mem_wr", 32'(mem_wr), 32'(m.wr));
            check("mem_rd", 32'(mem_rd), 32'(!m.wr));
            check("mem_address", 32'(mem_address), 32'(m.addr));
            check("mem_be", 32'(mem_be), 32'(m.be));
            check("mem_data_in", mem_data_in, m.data);
         end
      end
      if (s0.pready || s1.pready) begin
         if (s0.pready && s1.pready) check("pready_exclusive", 32'd1, 32'd0);
         if (resp_q.size() == 0) begin
            check("unexpected_pready", {s1.pready, s0.pready}, 32'd0);
         end else begin
            r = resp_q.pop_front();
            check("grant_port", 32'(s1.pready), 32'(r.port));
            if (r.port) begin
               check("s1_pslverr", 32'(s1.pslverr), 32'(r.err));
               check("s1_prdata", s1.prdata, r.rdata);
               check("s0_idle_outputs", {s0.pslverr, s0.prdata[30:0]}, 32'd0);
            end else begin
               check("s0_pslverr", 32'(s0.pslverr), 32'(r.err));
               check("s0_prdata", s0.prdata, r.rdata);
               check("s1_idle_outputs", {s1.pslverr, s1.prdata[30:0]}, 32'd0);
            end
         end
      end
   end

   // Protocol watch: granted psel must stay high for the whole transfer.
   always @(negedge clk) begin
      if (!rst && (dut.state_q != IDLE)) begin
         if (!(dut.grant_q ? s1.psel : s0.psel)) begin
            failures++;
            $display("FAIL psel_dropped: port %0d psel 0 required 1 at %0t", dut.grant_q, $time);
         end
      end
   end

   task automatic drive(input logic port, input logic sel, input logic en, input logic wr,
                        input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
      if (port) begin
         s1.psel = sel; s1.penable = en; s1.pwrite = wr;
         s1.paddr = a;  s1.pwdata = wd;  s1.pstrb = st;
      end else begin
         s0.psel = sel; s0.penable = en; s0.pwrite = wr;
         s0.paddr = a;  s0.pwdata = wd;  s0.pstrb = st;
      end
   endtask

   // One APB transfer; starts just after a posedge. exp_lat < 0 skips latency check.
   task automatic xfer(input logic port, input logic wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input int pen_delay, input int exp_lat);
      int  lat  = 0;
      bit  done = 0;
      drive(port, 1'b1, 1'b0, wr, a, wd, st);
      for (int cyc = 0; cyc < 64; cyc++) begin
         @(negedge clk);
         if (port ? s1.pready : s0.pready) begin
            done = 1;
            lat  = cyc;
            break;
         end
         @(posedge clk);
         #1;
         if (cyc + 1 >= 1 + pen_delay) drive(port, 1'b1, 1'b1, wr, a, wd, st);
      end
      @(posedge clk);
      #1;
      drive(port, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      if (!done) check("pready_timeout", 32'd0, 32'd1);
      else if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      check("rst_grant", 32'(dut.grant_q), 32'(PORT0));
      check("rst_mem_ctrl", {mem_wr, mem_rd, mem_be, mem_address}, 32'd0);
      check("rst_mem_data_in", mem_data_in, 32'd0);
      check("rst_s0_resp", {s0.pready, s0.pslverr, s0.prdata[29:0]}, 32'd0);
      check("rst_s1_resp", {s1.pready, s1.pslverr, s1.prdata[29:0]}, 32'd0);
      @(posedge clk);
      #1;

      // Partial write, then read back shows only low lanes updated.
      exp_mop(1'b1, 8'd4, 4'b0011, 32'hA5A5_1234);
      exp_resp(1'b0, 1'b0, 32'h0);
      xfer(1'b0, 1'b1, 12'h010, 32'hA5A5_1234, 4'b0011, 0, 2);
      exp_mop(1'b0, 8'd4, 4'b1111, 32'h0);
      exp_resp(1'b0, 1'b0, 32'h0000_1234);
      xfer(1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 0, 2);

      // Full-word writes, then port 1 reads.
      exp_mop(1'b1, 8'd4, 4'b1111, 32'hDEAD_BEEF);
      exp_resp(1'b0, 1'b0, 32'h0);
      xfer(1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'b1111, 0, 2);
      exp_mop(1'b1, 8'd5, 4'b1111, 32'hCAFE_0005);
      exp_resp(1'b0, 1'b0, 32'h0);
      xfer(1'b0, 1'b1, 12'h014, 32'hCAFE_0005, 4'b1111, 0, 2);
      exp_mop(1'b0, 8'd4, 4'b1111, 32'h0);
      exp_resp(1'b1, 1'b0, 32'hDEAD_BEEF);
      xfer(1'b1, 1'b0, 12'h010, 32'h0, 4'h0, 0, 2);

      // Contention: both ports issue two reads starting in the same cycle.
`ifdef APB_MEM_ARB_FIXED_PRIO_EN
      exp_mop(1'b0, 8'd4, 4'b1111, 32'h0); exp_resp(1'b0, 1'b0, 32'hDEAD_BEEF);
      exp_mop(1'b0, 8'd4, 4'b1111, 32'h0); exp_resp(1'b0, 1'b0, 32'hDEAD_BEEF);
      exp_mop(1'b0, 8'd5, 4'b1111, 32'h0); exp_resp(1'b1, 1'b0, 32'hCAFE_0005);
      exp_mop(1'b0, 8'd5, 4'b1111, 32'h0); exp_resp(1'b1, 1'b0, 32'hCAFE_0005);
`else
      exp_mop(1'b0, 8'd4, 4'b1111, 32'h0); exp_resp(1'b0, 1'b0, 32'hDEAD_BEEF);
      exp_mop(1'b0, 8'd5, 4'b1111, 32'h0); exp_resp(1'b1, 1'b0, 32'hCAFE_0005);
      exp_mop(1'b0, 8'd4, 4'b1111, 32'h0); exp_resp(1'b0, 1'b0, 32'hDEAD_BEEF);
      exp_mop(1'b0, 8'd5, 4'b1111, 32'h0); exp_resp(1'b1, 1'b0, 32'hCAFE_0005);
`endif
      fork
         begin
            xfer(1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 0, 2);
            xfer(1'b0, 1'b0, 12'h010, 32'h0, 4'h0, 0, -1);
         end
         begin
            xfer(1'b1, 1'b0, 12'h014, 32'h0, 4'h0, 0, -1);
            xfer(1'b1, 1'b0, 12'h014, 32'h0, 4'h0, 0, -1);
         end
      join
      check("contention_drained", 32'(resp_q.size()), 32'd0);

      // Out-of-range and misaligned reads: error, no strobe.
      exp_resp(1'b0, 1'b1, 32'h0);
      xfer(1'b0, 1'b0, 12'h400, 32'h0, 4'h0, 0, 2);
      exp_resp(1'b0, 1'b1, 32'h0);
      xfer(1'b0, 1'b0, 12'h002, 32'h0, 4'h0, 0, 2);

      // Late penable: strobe waits for it, pready one cycle later.
      exp_mop(1'b1, 8'd6, 4'b1111, 32'h1357_2468);
      exp_resp(1'b0, 1'b0, 32'h0);
      xfer(1'b0, 1'b1, 12'h018, 32'h1357_2468, 4'b1111, 2, 4);
      exp_mop(1'b0, 8'd6, 4'b1111, 32'h0);
      exp_resp(1'b1, 1'b0, 32'h1357_2468);
      xfer(1'b1, 1'b0, 12'h018, 32'h0, 4'h0, 0, 2);

      // Reset during the access phase of a write aborts it.
      exp_mop(1'b1, 8'd8, 4'b1111, 32'h1111_1111);
      exp_resp(1'b0, 1'b0, 32'h0);
      xfer(1'b0, 1'b1, 12'h020, 32'h1111_1111, 4'b1111, 0, 2);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h020, 32'h2222_2222, 4'b1111);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 12'h020, 32'h2222_2222, 4'b1111);
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_access_state", 32'(dut.state_q), 32'(ACCESS));
      check("rst_abort_mem_wr", 32'(mem_wr), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("rst_abort_state", 32'(dut.state_q), 32'(IDLE));
      check("rst_abort_grant", 32'(dut.grant_q), 32'(PORT0));
      check("rst_abort_pready", {s0.pready, s1.pready, mem_wr, mem_rd}, 32'd0);
      @(posedge clk);
      #1;
      exp_mop(1'b0, 8'd8, 4'b1111, 32'h0);
      exp_resp(1'b0, 1'b0, 32'h1111_1111);
      xfer(1'b0, 1'b0, 12'h020, 32'h0, 4'h0, 0, 2);

      repeat (4) @(posedge clk);
      check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
      check("mop_queue_empty", 32'(mop_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
